// File: rtl/sprite_motion_updater.sv
// sprite_motion_updater
// Per-frame sprite motion stage. A start pulse walks sprite entries
// 0..NUM_SPRITES-1: each entry is read (ISSUE/LOAD), its signed velocity is
// added to the 12.4 fixed-point position with bounce at the playfield edges
// (CALC), and all three attribute words are written back in one cycle (WRITE).
//
// Handshake: start is a single-cycle request sampled only in IDLE (ignored
// while busy, never queued); busy is high from the cycle after acceptance
// through the last write; done pulses for exactly one cycle after the last
// write, in which busy is already low and a new start is accepted.
module sprite_motion_updater #(
    parameter int NUM_SPRITES = 512,
    parameter int X_MAX       = 1023,
    parameter int Y_MAX       = 767
) (
    input  logic        clk_draw,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [8:0]  rd_index,
    input  logic [35:0] rd_y_height,
    input  logic [35:0] rd_x_width,
    input  logic [35:0] rd_velocity,
    output logic [8:0]  w_index,
    output logic [35:0] w_sprite_y_height,
    output logic        w_sprite_y_height_en,
    output logic [35:0] w_sprite_x_width,
    output logic        w_sprite_x_width_en,
    output logic [35:0] w_sprite_velocity,
    output logic        w_sprite_velocity_en,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_LOAD  = 3'd2,
        S_CALC  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    // Position limits in 1/16 pixel units
    localparam logic [15:0] X_LIM    = 16'(X_MAX * 16);
    localparam logic [15:0] Y_LIM    = 16'(Y_MAX * 16);
    localparam logic [8:0]  LAST_IDX = 9'(NUM_SPRITES - 1);

    state_t      state_q;
    logic [8:0]  idx_q;
    logic [35:0] yh_q;
    logic [35:0] xw_q;
    logic [35:0] vel_q;
    logic        busy_q;
    logic        done_q;
    logic [8:0]  rd_index_q;
    logic [8:0]  w_index_q;
    logic [35:0] wy_q;
    logic [35:0] wx_q;
    logic [35:0] wv_q;
    logic        wen_q;

    logic [15:0] y_p_d;
    logic [17:0] vy_d;
    logic [15:0] x_p_d;
    logic [17:0] vx_d;

    // One axis step: returns {new_p, new_v}. Zero velocity never moves or
    // clamps, so an out-of-range sprite at rest stays where it is.
    function automatic logic [33:0] axis_step(input logic [15:0] p,
                                              input logic [17:0] v,
                                              input logic [15:0] lim);
        logic signed [19:0] s;
        logic [17:0]        v_neg;
        logic [15:0]        np;
        logic [17:0]        nv;
        s     = $signed({4'b0000, p}) + $signed({{2{v[17]}}, v});
        // -131072 has no positive counterpart in 18 bits; saturate
        v_neg = (v == 18'h20000) ? 18'h1FFFF : (~v + 18'd1);
        if (v == 18'd0) begin
            np = p;
            nv = v;
        end else if (s < 0) begin
            np = 16'd0;
            nv = v_neg;
        end else if (s > $signed({4'b0000, lim})) begin
            np = lim;
            nv = v_neg;
        end else begin
            np = s[15:0];
            nv = v;
        end
        return {np, nv};
    endfunction

    // New position/velocity for both axes from the captured words
    always_comb begin
        {y_p_d, vy_d} = axis_step(yh_q[15:0], vel_q[17:0], Y_LIM);
        {x_p_d, vx_d} = axis_step(xw_q[15:0], vel_q[35:18], X_LIM);
    end

    // Sequencer: ISSUE -> LOAD -> CALC -> WRITE per sprite, all outputs registered
    always_ff @(posedge clk_draw or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 9'd0;
            yh_q       <= 36'd0;
            xw_q       <= 36'd0;
            vel_q      <= 36'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_index_q <= 9'd0;
            w_index_q  <= 9'd0;
            wy_q       <= 36'd0;
            wx_q       <= 36'd0;
            wv_q       <= 36'd0;
            wen_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        idx_q      <= 9'd0;
                        rd_index_q <= 9'd0;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    // BRAM data is valid at the end of this cycle
                    yh_q    <= rd_y_height;
                    xw_q    <= rd_x_width;
                    vel_q   <= rd_velocity;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    wy_q      <= {yh_q[35:16], y_p_d};
                    wx_q      <= {xw_q[35:16], x_p_d};
                    wv_q      <= {vx_d, vy_d};
                    w_index_q <= idx_q;
                    wen_q     <= 1'b1;
                    state_q   <= S_WRITE;
                end
                S_WRITE: begin
                    wen_q <= 1'b0;
                    if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        idx_q      <= idx_q + 9'd1;
                        rd_index_q <= idx_q + 9'd1;
                        state_q    <= S_ISSUE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign rd_index             = rd_index_q;
    assign w_index              = w_index_q;
    assign w_sprite_y_height    = wy_q;
    assign w_sprite_x_width     = wx_q;
    assign w_sprite_velocity    = wv_q;
    assign w_sprite_y_height_en = wen_q;
    assign w_sprite_x_width_en  = wen_q;
    assign w_sprite_velocity_en = wen_q;
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_sprite_motion_updater.sv
// Bench for sprite_motion_updater: 1-cycle-latency BRAM model, directed
// entries with hand-computed results, frame timing and mid-frame reset.
module tb_sprite_motion_updater;

  localparam int N = 512;

  logic        clk_draw = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  rd_index;
  logic [35:0] rd_y_height;
  logic [35:0] rd_x_width;
  logic [35:0] rd_velocity;
  logic [8:0]  w_index;
  logic [35:0] w_y;
  logic        w_y_en;
  logic [35:0] w_x;
  logic        w_x_en;
  logic [35:0] w_v;
  logic        w_v_en;
  logic [2:0]  dbg_state;

  sprite_motion_updater #(.NUM_SPRITES(N), .X_MAX(1023), .Y_MAX(767)) dut (
    .clk_draw(clk_draw), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_index(rd_index), .rd_y_height(rd_y_height), .rd_x_width(rd_x_width),
    .rd_velocity(rd_velocity), .w_index(w_index),
    .w_sprite_y_height(w_y), .w_sprite_y_height_en(w_y_en),
    .w_sprite_x_width(w_x), .w_sprite_x_width_en(w_x_en),
    .w_sprite_velocity(w_v), .w_sprite_velocity_en(w_v_en),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_draw = ~clk_draw;

  int cyc = 0;
  always @(posedge clk_draw) cyc <= cyc + 1;

  // ---------------- BRAM model ----------------
  logic [35:0] mem_y [0:N-1];
  logic [35:0] mem_x [0:N-1];
  logic [35:0] mem_v [0:N-1];

  always @(posedge clk_draw) begin
    rd_y_height <= mem_y[rd_index];
    rd_x_width  <= mem_x[rd_index];
    rd_velocity <= mem_v[rd_index];
    if (w_y_en) mem_y[w_index] = w_y;
    if (w_x_en) mem_x[w_index] = w_x;
    if (w_v_en) mem_v[w_index] = w_v;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [35:0] exp_y [0:N-1];
  logic [35:0] exp_x [0:N-1];
  logic [35:0] exp_v [0:N-1];
  logic [8:0]  exp_q[$];

  int busy_cnt, done_cnt, done_cyc, first_wr, last_wr, wr_cnt;

  // write/done monitor, sampled mid-cycle
  always @(negedge clk_draw) begin
    logic [8:0] e;
    if (busy === 1'b1) busy_cnt++;
    if ((w_y_en | w_x_en | w_v_en) === 1'b1) begin
      check_eq("wr_en_all", {w_y_en, w_x_en, w_v_en}, 3'b111);
      check_eq("wr_expected", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("wr_index", w_index, e);
      end
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      check_eq("busy_in_done", busy, 1'b0);
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [35:0] wd(input logic [19:0] other, input int scr, input int sub);
    return {other, 12'(scr), 4'(sub)};
  endfunction

  function automatic logic [35:0] vel(input int vx, input int vy);
    return {18'(vx), 18'(vy)};
  endfunction

  task automatic set_entry(input int i, input logic [35:0] y, input logic [35:0] x, input logic [35:0] v,
                           input logic [35:0] ey, input logic [35:0] ex, input logic [35:0] ev);
    mem_y[i] = y; mem_x[i] = x; mem_v[i] = v;
    exp_y[i] = ey; exp_x[i] = ex; exp_v[i] = ev;
  endtask

  task automatic arm_frame();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(9'(i));
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; first_wr = -1; last_wr = -1; wr_cnt = 0;
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clk_draw);
    t0 = cyc;
    start = 1'b1;
    @(negedge clk_draw);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done !== 1'b1 && guard < 5000) begin
      @(negedge clk_draw);
      guard++;
    end
    check_eq("done_seen", done, 1'b1);
    repeat (3) @(negedge clk_draw);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctrl"}, {busy, done, rd_index, w_index, w_y_en, w_x_en, w_v_en}, 64'd0);
    check_eq({tag, "_wy"}, w_y, 36'd0);
    check_eq({tag, "_wx"}, w_x, 36'd0);
    check_eq({tag, "_wv"}, w_v, 36'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int guard;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk_draw);
    check_idle_outputs("reset");
    check_eq("reset_state", dbg_state, 3'd0);
    rst = 1'b0;

    // frame 1: background entries at rest (including out-of-range ones)
    for (int i = 0; i < N; i++)
      set_entry(i, wd(20'(i * 7), i % 768, i % 16), wd(20'(i * 13 + 5), (i * 3) % 4096, (i + 5) % 16), 36'd0,
                wd(20'(i * 7), i % 768, i % 16), wd(20'(i * 13 + 5), (i * 3) % 4096, (i + 5) % 16), 36'd0);
    // basic motion: x 100.0 +24 -> 101.8, y 50.0 -16 -> 49.0
    set_entry(0, wd(20'hABCDE, 50, 0), wd(20'h12345, 100, 0), vel(24, -16),
                 wd(20'hABCDE, 49, 0), wd(20'h12345, 101, 8), vel(24, -16));
    // low bounce: y 0.4 -8 -> 0.0, vy +8; x at rest
    set_entry(1, wd(20'h0F0F0, 0, 4), wd(20'h00001, 200, 3), vel(0, -8),
                 wd(20'h0F0F0, 0, 0), wd(20'h00001, 200, 3), vel(0, 8));
    // high bounce: x 1023.0 +16 -> s=16384 > 16368
    set_entry(2, wd(20'h11111, 300, 0), wd(20'h22222, 1023, 0), vel(16, 0),
                 wd(20'h11111, 300, 0), wd(20'h22222, 1023, 0), vel(-16, 0));
    // saturation: vy -131072 from y 10 -> 0, vy +131071
    set_entry(3, wd(20'h33333, 10, 0), wd(20'h44444, 5, 5), {18'd0, 18'h20000},
                 wd(20'h33333, 0, 0), wd(20'h44444, 5, 5), {18'd0, 18'h1FFFF});
    // x lands exactly on limit (no bounce); y 12270+3 > 12272 bounces
    set_entry(4, wd(20'h55555, 766, 14), wd(20'h66666, 1022, 0), vel(16, 3),
                 wd(20'h55555, 767, 0), wd(20'h66666, 1023, 0), vel(16, -3));
    // out of range at rest stays put
    set_entry(5, wd(20'h77777, 1000, 0), wd(20'h88888, 4000, 9), 36'd0,
                 wd(20'h77777, 1000, 0), wd(20'h88888, 4000, 9), 36'd0);
    // out of range moving: x 2000.0 -16 -> clamp 1023.0, vx +16
    set_entry(6, wd(20'h99999, 20, 0), wd(20'hAAAAA, 2000, 0), vel(-16, 0),
                 wd(20'h99999, 20, 0), wd(20'hAAAAA, 1023, 0), vel(16, 0));
    // lands exactly on 0 (no bounce)
    set_entry(7, wd(20'hBBBBB, 1, 0), wd(20'hCCCCC, 0, 0), vel(0, -16),
                 wd(20'hBBBBB, 0, 0), wd(20'hCCCCC, 0, 0), vel(0, -16));

    arm_frame();
    pulse_start(t0);
    check_eq("busy_after_start", busy, 1'b1);
    // a second start mid-frame must be ignored
    guard = 0;
    while (cyc < t0 + 100 && guard < 200) begin
      @(negedge clk_draw);
      guard++;
    end
    start = 1'b1;
    @(negedge clk_draw);
    start = 1'b0;
    wait_done();
    check_eq("f1_first_wr", first_wr, t0 + 4);
    check_eq("f1_last_wr", last_wr, t0 + 4 * N);
    check_eq("f1_done_cyc", done_cyc, t0 + 4 * N + 1);
    check_eq("f1_busy_cycles", busy_cnt, 4 * N);
    check_eq("f1_done_pulses", done_cnt, 1);
    check_eq("f1_writes", wr_cnt, N);
    check_eq("f1_done_low", done, 1'b0);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("f1_y[%0d]", i), mem_y[i], exp_y[i]);
      check_eq($sformatf("f1_x[%0d]", i), mem_x[i], exp_x[i]);
      check_eq($sformatf("f1_v[%0d]", i), mem_v[i], exp_v[i]);
    end

    // reset mid-frame: every entry moves x 100.0 -> 101.0
    for (int i = 0; i < N; i++)
      set_entry(i, wd(20'(i), 50, 0), wd(20'(i + 1), 100, 0), vel(16, 0),
                   wd(20'(i), 50, 0), wd(20'(i + 1), 101, 0), vel(16, 0));
    arm_frame();
    pulse_start(t0);
    guard = 0;
    while (cyc < t0 + 43 && guard < 200) begin
      @(negedge clk_draw);
      guard++;
    end
    check_eq("sprite10_calc", dbg_state, 3'd3);
    rst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    check_eq("midreset_state", dbg_state, 3'd0);
    check_eq("midreset_writes", wr_cnt, 10);
    @(negedge clk_draw);
    rst = 1'b0;
    for (int i = 0; i < 12; i++)
      check_eq($sformatf("mr_x[%0d]", i), mem_x[i], (i < 10) ? wd(20'(i + 1), 101, 0) : wd(20'(i + 1), 100, 0));

    // restart begins at index 0
    arm_frame();
    pulse_start(t0);
    wait_done();
    check_eq("rs_first_wr", first_wr, t0 + 4);
    check_eq("rs_done_cyc", done_cyc, t0 + 4 * N + 1);
    check_eq("rs_writes", wr_cnt, N);
    check_eq("rs_x0", mem_x[0], wd(20'd1, 102, 0));
    check_eq("rs_x10", mem_x[10], wd(20'd11, 101, 0));
    check_eq("rs_x511", mem_x[511], wd(20'd512, 101, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
